// File: rtl/mem_copy_engine.sv
// Word-granular memory copy/fill engine: copies length words from src to dst
// (2 cycles/word) or fills dst with a constant (1 cycle/word) over a single-port memory.
module mem_copy_engine #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             fill_mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_val,
  output logic             mem_wr_enb,
  output logic [31:0]      mem_wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] r_count;
  logic [31:0]      r_data;
  logic             r_fill_mode;
  logic [31:0]      r_fill_value;
  logic             w_launch;

  // Abort outranks start, so a simultaneous request never launches.
  assign w_launch = start && !abort;

  always_comb begin
    w_next      = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    mem_addr    = 32'd0;
    mem_wr_enb  = 1'b0;
    mem_wr_data = 32'd0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_launch) begin
          if (length == '0)    w_next = S_DONE;
          else if (fill_mode)  w_next = S_WRITE;
          else                 w_next = S_READ;
        end
      end
      S_READ: begin
        mem_addr = r_src;
        w_next   = abort ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        mem_addr    = r_dst;
        mem_wr_enb  = !abort;
        mem_wr_data = r_fill_mode ? r_fill_value : r_data;
        if (abort)                      w_next = S_IDLE;
        else if (r_rem == LEN_W'(1))    w_next = S_DONE;
        else if (r_fill_mode)           w_next = S_WRITE;
        else                            w_next = S_READ;
      end
      S_DONE: begin
        done   = !abort;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_src        <= 32'd0;
      r_dst        <= 32'd0;
      r_rem        <= '0;
      r_count      <= '0;
      r_data       <= 32'd0;
      r_fill_mode  <= 1'b0;
      r_fill_value <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_src        <= src_addr;
            r_dst        <= dst_addr;
            r_rem        <= length;
            r_count      <= '0;
            r_fill_mode  <= fill_mode;
            r_fill_value <= fill_value;
          end
        end
        S_READ: begin
          if (!abort) r_data <= mem_val;
        end
        S_WRITE: begin
          // Pointers wrap naturally at 2^32; an aborted write does not advance.
          if (!abort) begin
            r_dst   <= r_dst + 32'd1;
            r_rem   <= r_rem - LEN_W'(1);
            r_count <= r_count + LEN_W'(1);
            if (!r_fill_mode) r_src <= r_src + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: copy, fill, zero length, wrap, abort and reset cases
// against a 16-word behavioural memory indexed by the low address bits.
module tb_mem_copy_engine;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             fill_mode;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] length;
  logic [31:0]      fill_value;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] count;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_val;
  logic             mem_wr_enb;
  logic [31:0]      mem_wr_data;

  logic [31:0] mem [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [31:0] pl_data;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .fill_mode  (fill_mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .mem_addr   (mem_addr),
    .mem_val    (mem_val),
    .mem_wr_enb (mem_wr_enb),
    .mem_wr_data(mem_wr_data)
  );

  assign mem_val = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (pl_en)           mem[pl_addr] <= pl_data;
    else if (mem_wr_enb) mem[mem_addr[3:0]] <= mem_wr_data;
  end

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) preload(4'(i), 32'd0);
  endtask

  // Presents start for one edge; returns at 1 time unit after the sampling edge.
  task automatic kick(input logic fm, input logic [31:0] s, input logic [31:0] d,
                      input logic [LEN_W-1:0] len, input logic [31:0] fv);
    @(negedge clk);
    fill_mode = fm; src_addr = s; dst_addr = d; length = len; fill_value = fv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({busy, done, mem_wr_enb} !== 3'b000) $display("FAIL reset_ctrl busy/done/we=%b expected 000", {busy, done, mem_wr_enb});
    else n_pass++;
    n_total++;
    if (count !== '0 || mem_addr !== 32'd0 || mem_wr_data !== 32'd0)
      $display("FAIL reset_data count=%0d addr=%h wdata=%h expected 0/0/0", count, mem_addr, mem_wr_data);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset busy=%b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_idle_abort();
    @(negedge clk);
    abort = 1'b1; start = 1'b1; fill_mode = 1'b1; dst_addr = 32'd1; length = 16'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_total++;
    if (busy !== 1'b0 || mem_wr_enb !== 1'b0) $display("FAIL start_abort_idle busy=%b we=%b expected 0 0", busy, mem_wr_enb);
    else n_pass++;
  endtask

  task automatic test_copy();
    int n;
    clear_mem();
    preload(4'd0, 32'hA); preload(4'd1, 32'hB); preload(4'd2, 32'hC); preload(4'd3, 32'hD);
    kick(1'b0, 32'd0, 32'd8, 16'd4, 32'd0);
    n = 1;
    while (done !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    n_total++;
    if (n !== 9) $display("FAIL copy_latency done_at=%0d expected 9", n);
    else n_pass++;
    n_total++;
    if (count !== 16'd4) $display("FAIL copy_count count=%0d expected 4", count);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL copy_idle busy=%b done=%b expected 0 0", busy, done);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (mem[8+i] !== 32'hA + 32'(i)) $display("FAIL copy_data mem[%0d]=%h expected %h", 8+i, mem[8+i], 32'hA + 32'(i));
      else n_pass++;
    end
  endtask

  task automatic test_fill();
    clear_mem();
    kick(1'b1, 32'd0, 32'd2, 16'd3, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (mem_wr_enb !== 1'b1 || mem_addr !== 32'd2 + 32'(i) || mem_wr_data !== 32'hDEADBEEF)
        $display("FAIL fill_write%0d we=%b addr=%h data=%h expected 1 %h deadbeef", i, mem_wr_enb, mem_addr, mem_wr_data, 32'd2 + 32'(i));
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if (done !== 1'b1 || mem_wr_enb !== 1'b0 || count !== 16'd3)
      $display("FAIL fill_done done=%b we=%b count=%0d expected 1 0 3", done, mem_wr_enb, count);
    else n_pass++;
    n_total++;
    if (mem[1] !== 32'd0 || mem[2] !== 32'hDEADBEEF || mem[4] !== 32'hDEADBEEF || mem[5] !== 32'd0)
      $display("FAIL fill_mem m1=%h m2=%h m4=%h m5=%h expected 0 deadbeef deadbeef 0", mem[1], mem[2], mem[4], mem[5]);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len();
    kick(1'b0, 32'd0, 32'd8, 16'd0, 32'd0);
    n_total++;
    if (done !== 1'b1 || busy !== 1'b1 || mem_wr_enb !== 1'b0)
      $display("FAIL zero_len_done done=%b busy=%b we=%b expected 1 1 0", done, busy, mem_wr_enb);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0 || mem_wr_enb !== 1'b0)
      $display("FAIL zero_len_idle done=%b busy=%b we=%b expected 0 0 0", done, busy, mem_wr_enb);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFFFFFE; exp_a[1] = 32'hFFFFFFFF; exp_a[2] = 32'h00000000;
    kick(1'b1, 32'd0, 32'hFFFFFFFE, 16'd3, 32'h55AA55AA);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (mem_wr_enb !== 1'b1 || mem_addr !== exp_a[i])
        $display("FAIL wrap_addr%0d we=%b addr=%h expected 1 %h", i, mem_wr_enb, mem_addr, exp_a[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if (done !== 1'b1 || count !== 16'd3) $display("FAIL wrap_done done=%b count=%0d expected 1 3", done, count);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    clear_mem();
    preload(4'd0, 32'hA); preload(4'd1, 32'hB); preload(4'd2, 32'hC); preload(4'd3, 32'hD);
    kick(1'b0, 32'd0, 32'd8, 16'd4, 32'd0);
    @(posedge clk); #1;
    n_total++;
    if (mem_wr_enb !== 1'b1 || mem_addr !== 32'd8) $display("FAIL abort_first_write we=%b addr=%h expected 1 8", mem_wr_enb, mem_addr);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    #1;
    n_total++;
    if (mem_wr_enb !== 1'b0 || done !== 1'b0 || busy !== 1'b1)
      $display("FAIL abort_cycle we=%b done=%b busy=%b expected 0 0 1", mem_wr_enb, done, busy);
    else n_pass++;
    @(posedge clk); #1;
    abort = 1'b0;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 16'd1)
      $display("FAIL abort_idle busy=%b done=%b count=%0d expected 0 0 1", busy, done, count);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (mem[8] !== 32'hA || mem[9] !== 32'd0 || done !== 1'b0)
      $display("FAIL abort_mem m8=%h m9=%h done=%b expected a 0 0", mem[8], mem[9], done);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    clear_mem();
    kick(1'b1, 32'd0, 32'd5, 16'd4, 32'h12345678);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, mem_wr_enb} !== 3'b000 || count !== '0 || mem_addr !== 32'd0 || mem_wr_data !== 32'd0)
      $display("FAIL reset_mid_outputs bdw=%b count=%0d addr=%h wdata=%h expected 000 0 0 0",
               {busy, done, mem_wr_enb}, count, mem_addr, mem_wr_data);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (mem_wr_enb !== 1'b0 || mem[5] !== 32'h12345678 || mem[6] !== 32'd0)
      $display("FAIL reset_mid_mem we=%b m5=%h m6=%h expected 0 12345678 0", mem_wr_enb, mem[5], mem[6]);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    kick(1'b1, 32'd0, 32'd9, 16'd2, 32'hCAFE0001);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_total++;
    if (n !== 3 || count !== 16'd2) $display("FAIL restart_done done_at=%0d count=%0d expected 3 2", n, count);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (mem[9] !== 32'hCAFE0001 || mem[10] !== 32'hCAFE0001 || mem[11] !== 32'd0)
      $display("FAIL restart_mem m9=%h m10=%h m11=%h expected cafe0001 cafe0001 0", mem[9], mem[10], mem[11]);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fill_mode = 1'b0;
    src_addr = 32'd0; dst_addr = 32'd0; length = '0; fill_value = 32'd0;
    pl_en = 1'b0; pl_addr = 4'd0; pl_data = 32'd0;
    test_reset();
    test_idle_abort();
    test_copy();
    test_fill();
    test_zero_len();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 The block SHALL have parameter LEN_W, default 16, meaning the width of the word-count fields.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-004 Port start, input, 1 bit, SHALL request a new operation; it is sampled only in IDLE.
REQ-005 Port abort, input, 1 bit, SHALL cancel the operation in progress.
REQ-006 Port fill_mode, input, 1 bit, SHALL select the operation: 0 = copy, 1 = fill with fill_value.
REQ-007 Port src_addr, input, 32 bits, SHALL give the copy source word address.
REQ-008 Port dst_addr, input, 32 bits, SHALL give the destination word address.
REQ-009 Port length, input, LEN_W bits, SHALL give the number of words to transfer.
REQ-010 Port fill_value, input, 32 bits, SHALL give the word written in fill mode.
REQ-011 Port busy, output, 1 bit, SHALL be high in every state except IDLE.
REQ-012 Port done, output, 1 bit, SHALL pulse high for one cycle on normal completion.
REQ-013 Port count, output, LEN_W bits, SHALL give the number of words written so far in the current or last operation.
REQ-014 Port mem_addr, output, 32 bits, SHALL drive the data memory address.
REQ-015 Port mem_val, input, 32 bits, SHALL carry the data memory combinational read data for mem_addr.
REQ-016 Port mem_wr_enb, output, 1 bit, SHALL be the data memory write enable, sampled by the memory at the clk rising edge.
REQ-017 Port mem_wr_data, output, 32 bits, SHALL be the data memory write data.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, READ, WRITE and DONE.
REQ-019 On start=1 in IDLE, the block SHALL latch src, dst, length, fill_mode and fill_value, and clear count to 0.
REQ-020 After that latch, the next state SHALL be:
- DONE if length=0;
- WRITE if fill_mode=1;
- READ otherwise.
REQ-021 start SHALL be ignored outside IDLE; the latched operands SHALL stay unchanged while busy.
REQ-022 In READ, the block SHALL:
- drive mem_addr = src pointer and mem_wr_enb = 0;
- capture mem_val into the data register at the clock edge;
- go to WRITE.
REQ-023 In WRITE, the block SHALL drive mem_addr = dst pointer and mem_wr_enb = 1.
REQ-024 In WRITE, mem_wr_data SHALL be the data register in copy mode and fill_value in fill mode.
REQ-025 At each WRITE edge, the block SHALL increment the dst pointer, the src pointer (copy mode only) and count, and decrement the remaining count.
REQ-026 Leaving WRITE, the block SHALL go to DONE if remaining was 1; otherwise it SHALL go to READ (copy) or stay in WRITE (fill).
REQ-027 Throughput SHALL be 2 cycles per word in copy mode and 1 cycle per word in fill mode.
REQ-028 In DONE, the block SHALL drive done = 1 for exactly one cycle, then go to IDLE.
REQ-029 Pointers SHALL wrap modulo 2^32 (0xFFFFFFFF + 1 = 0x00000000), with no error.
REQ-030 Copies SHALL run in ascending address order only; overlapping regions with dst > src produce replicated data, and this is defined behaviour.
REQ-031 abort=1 in READ, WRITE or DONE SHALL force mem_wr_enb = 0 and done = 0 in that cycle, and return the FSM to IDLE at the next edge; count SHALL hold the words already written.
REQ-032 abort in IDLE SHALL have no effect; abort and start together in IDLE SHALL mean abort wins and no operation starts.
REQ-033 In IDLE and DONE, the block SHALL drive mem_addr = 0, mem_wr_enb = 0 and mem_wr_data = 0.

Reset
REQ-034 While rst_n = 0, asynchronously, the block SHALL set:
- state to IDLE;
- busy, done and mem_wr_enb to 0;
- count, pointers, remaining and the data register to 0.
REQ-035 Reset mid-operation SHALL abandon the transfer immediately with no further writes; memory contents already written are kept.

Verification
REQ-036 The bench SHALL cover a copy: memory[0..3] = 0xA,0xB,0xC,0xD; start copy src=0, dst=8, length=4 -> memory[8..11] = 0xA..0xD, done 9 cycles after the start edge, count = 4.
REQ-037 The bench SHALL cover a fill: fill_value = 0xDEADBEEF, dst=2, length=3 -> exactly 3 consecutive write cycles to addresses 2, 3, 4, then done, count = 3.
REQ-038 The bench SHALL cover length = 0: start -> no mem_wr_enb, done pulse one cycle after start, busy high for 1 cycle.
REQ-039 The bench SHALL cover wrap-around: fill dst=0xFFFFFFFE, length=3 -> writes to 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-040 The bench SHALL cover abort: copy length=4 with abort during the 2nd WRITE -> only 1 word written, no done pulse, idle next cycle, count = 1.
REQ-041 The bench SHALL cover reset mid-operation: rst_n low during a fill -> mem_wr_enb = 0 immediately, all outputs at reset values, and a new start after release works normally.
